// File: rtl/comparador_pkg.sv
// comparador_pkg: shared FSM states, result encoding and digit-count helper
package comparador_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_LT = 2'b01;
    localparam logic [1:0] RES_GT = 2'b10;
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction
endpackage

// File: rtl/comparador_digito.sv
// comparador_digito: combinational unsigned compare of one DIGIT-bit digit
module comparador_digito #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    assign lt = a < b;
    assign eq = a == b;
    assign gt = a > b;
endmodule

// File: rtl/comparador_serial.sv
// comparador_serial: multi-cycle magnitude comparator scanning DIGIT bits per clock,
// LSB-first with fixed latency or MSB-first with early termination
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] wordA,
    input  logic [WIDTH-1:0] wordB,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             z
);
    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_chk
        $error("comparador_serial: WIDTH must be a multiple of DIGIT");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, b;
    logic             mode;
    logic [CW-1:0]    cnt;
    logic [1:0]       run, run_nxt;
    logic             d_lt, d_eq, d_gt, fin;
    logic [DIGIT-1:0] a_dig [2**CW];
    logic [DIGIT-1:0] b_dig [2**CW];

    // digit table padded to a power of two so the counter indexes it exactly
    for (genvar i = 0; i < 2**CW; i++) begin : g_dig
        if (i < NDIG) begin : g_v
            assign a_dig[i] = a[i*DIGIT +: DIGIT];
            assign b_dig[i] = b[i*DIGIT +: DIGIT];
        end else begin : g_z
            assign a_dig[i] = '0;
            assign b_dig[i] = '0;
        end
    end

    comparador_digito #(.DIGIT(DIGIT)) u_digito (
        .a  (a_dig[cnt]),
        .b  (b_dig[cnt]),
        .lt (d_lt),
        .eq (d_eq),
        .gt (d_gt)
    );

    // a differing digit overrides the running result; for MSB-first it also ends the scan
    always_comb begin
        run_nxt   = d_gt ? RES_GT : d_lt ? RES_LT : run;
        fin       = mode ? (!d_eq || cnt == '0) : (cnt == LAST);
        state_nxt = state == IDLE ? (start ? SCAN : IDLE) :
                    state == SCAN ? (fin ? DONE : SCAN) : IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a    <= '0;
            b    <= '0;
            mode <= 1'b0;
            cnt  <= '0;
            run  <= RES_EQ;
            lt   <= 1'b0;
            eq   <= 1'b0;
            gt   <= 1'b0;
            z    <= 1'b0;
        end else if (state == IDLE && start) begin
            a    <= wordA;
            b    <= wordB;
            mode <= dir;
            cnt  <= dir ? LAST : '0;
            run  <= RES_EQ;
        end else if (state == SCAN) begin
            run <= run_nxt;
            cnt <= mode ? cnt - CW'(1) : cnt + CW'(1);
            if (fin) begin
                lt <= run_nxt == RES_LT;
                eq <= run_nxt == RES_EQ;
                gt <= run_nxt == RES_GT;
                z  <= run_nxt != RES_GT;
            end
        end
    end

    assign busy = state == SCAN;
    assign done = state == DONE;
endmodule

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial: directed table, corner sequences and random ops on an
// 8x1 and a 16x4 instance, checked against an arithmetic reference model
module tb_comparador_serial;
    logic clk = 1'b0;
    logic reset8, start8, dir8, busy8, done8, lt8, eq8, gt8, z8;
    logic [7:0] a8, b8;
    logic reset16, start16, dir16, busy16, done16, lt16, eq16, gt16, z16;
    logic [15:0] a16, b16;
    int pass = 0, total = 0;
    logic [3:0] prev8, prev16;

    always #5 clk = ~clk;

    comparador_serial #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .reset(reset8), .start(start8), .dir(dir8), .wordA(a8), .wordB(b8),
        .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8), .z(z8));

    comparador_serial #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .reset(reset16), .start(start16), .dir(dir16), .wordA(a16), .wordB(b16),
        .busy(busy16), .done(done16), .lt(lt16), .eq(eq16), .gt(gt16), .z(z16));

    typedef struct {
        bit         w;
        logic [15:0] a, b;
        logic       d;
        int         lat;
        logic [3:0] res;
    } vec_t;
    vec_t vec [9];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h want=%h", name, got, exp);
        else pass++;
    endtask

    task automatic drive(input bit w, input logic s, input logic d, input logic [15:0] av, input logic [15:0] bv);
        if (w) begin start16 = s; dir16 = d; a16 = av; b16 = bv; end
        else begin start8 = s; dir8 = d; a8 = av[7:0]; b8 = bv[7:0]; end
    endtask

    function automatic logic [5:0] outs(input bit w);
        return w ? {busy16, done16, lt16, eq16, gt16, z16} : {busy8, done8, lt8, eq8, gt8, z8};
    endfunction

    // result {lt,eq,gt,z} from plain comparison; MSB-first latency = digits scanned up to first difference
    function automatic void model(input bit w, input logic [15:0] a, input logic [15:0] b, input logic d,
                                  output int lat, output logic [3:0] res);
        int nd = w ? 4 : 8;
        int dg = w ? 4 : 1;
        int mask = (1 << dg) - 1;
        int ai = int'(a);
        int bi = int'(b);
        res = ai < bi ? 4'b1001 : ai == bi ? 4'b0101 : 4'b0010;
        lat = nd;
        if (d)
            for (int k = nd - 1; k >= 0; k--)
                if (((ai >> (k * dg)) & mask) != ((bi >> (k * dg)) & mask)) begin
                    lat = nd - k;
                    break;
                end
    endfunction

    task automatic op(input bit w, input logic [15:0] av, input logic [15:0] bv, input logic d,
                      input bit meddle, input int exp_lat, input logic [3:0] exp_res, input string name);
        int lat = 0;
        logic [5:0] o;
        @(negedge clk); drive(w, 1'b1, d, av, bv);
        @(posedge clk);
        @(negedge clk); drive(w, 1'b0, d, av, bv);
        o = outs(w);
        check({name, " busy/done after accept"}, {14'd0, o[5:4]}, 16'h0002);
        check({name, " results held"}, {12'd0, o[3:0]}, {12'd0, w ? prev16 : prev8});
        do begin
            @(posedge clk); lat++;
            @(negedge clk); o = outs(w);
            if (!o[4]) check({name, " busy in scan"}, {15'd0, o[5]}, 16'h0001);
            if (meddle && lat == 2) drive(w, 1'b1, ~d, 16'hFFFF, 16'h0000);
            if (meddle && lat == 3) drive(w, 1'b0, d, av, bv);
        end while (!o[4] && lat < 40);
        check({name, " latency"}, 16'(lat), 16'(exp_lat));
        check({name, " result"}, {12'd0, o[3:0]}, {12'd0, exp_res});
        if (w) prev16 = exp_res; else prev8 = exp_res;
        @(negedge clk); o = outs(w);
        check({name, " done one cycle"}, {14'd0, o[5:4]}, 16'h0000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, cyc, d1, d2;
        bit seen;
        logic [3:0] res;
        logic [15:0] av, bv;
        bit w;
        logic d;
        vec[0] = '{1'b0, 16'h00, 16'h00, 1'b0, 8, 4'b0101};
        vec[1] = '{1'b0, 16'hE7, 16'h81, 1'b0, 8, 4'b0010};
        vec[2] = '{1'b0, 16'h80, 16'h7F, 1'b1, 1, 4'b0010};
        vec[3] = '{1'b0, 16'h80, 16'h7F, 1'b0, 8, 4'b0010};
        vec[4] = '{1'b0, 16'h0A, 16'h09, 1'b1, 7, 4'b0010};
        vec[5] = '{1'b0, 16'h00, 16'h01, 1'b1, 8, 4'b1001};
        vec[6] = '{1'b1, 16'h1234, 16'h1235, 1'b0, 4, 4'b1001};
        vec[7] = '{1'b1, 16'h1234, 16'h1235, 1'b1, 4, 4'b1001};
        vec[8] = '{1'b1, 16'hF000, 16'h0FFF, 1'b1, 1, 4'b0010};
        reset8 = 1'b1; reset16 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        prev8 = 4'b0000; prev16 = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset outs 8", {10'd0, outs(1'b0)}, 16'h0000);
        check("reset outs 16", {10'd0, outs(1'b1)}, 16'h0000);
        reset8 = 1'b0; reset16 = 1'b0;
        @(negedge clk);
        check("idle outs 8", {10'd0, outs(1'b0)}, 16'h0000);

        for (int i = 0; i < 9; i++)
            op(vec[i].w, vec[i].a, vec[i].b, vec[i].d, 1'b0, vec[i].lat, vec[i].res, $sformatf("vec%0d", i));

        // abort mid-scan with async reset
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 16'hFF, 16'h00);
        @(posedge clk);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 16'hFF, 16'h00);
        repeat (3) @(posedge clk);
        #2 reset8 = 1'b1;
        #1 check("abort outs", {10'd0, outs(1'b0)}, 16'h0000);
        @(negedge clk); reset8 = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); seen |= done8 | busy8; end
        check("abort no done", {15'd0, seen}, 16'h0000);
        prev8 = 4'b0000;
        op(1'b0, 16'h00, 16'h01, 1'b0, 1'b0, 8, 4'b1001, "restart");

        // start and operands disturbed during scan must be ignored
        op(1'b1, 16'h1234, 16'h1235, 1'b0, 1'b1, 4, 4'b1001, "meddle");

        // start held high: back-to-back ops, done pulses 4 scan + DONE + IDLE apart
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 16'h00FF, 16'h00FE);
        cyc = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && cyc < 60) begin
            @(negedge clk); cyc++;
            if (done16) begin if (d1 < 0) d1 = cyc; else d2 = cyc; end
        end
        check("continuous gap", 16'(d2 - d1), 16'd6);
        check("continuous result", {12'd0, lt16, eq16, gt16, z16}, 16'h0002);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (8) @(negedge clk);
        prev16 = 4'b0010;

        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            av = 16'($urandom);
            bv = $urandom_range(0, 3) == 0 ? av : $urandom_range(0, 1) ? av ^ 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            if (!w) begin av &= 16'h00FF; bv &= 16'h00FF; end
            model(w, av, bv, d, lat, res);
            op(w, av, bv, d, 1'b0, lat, res, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
